// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: steers program_counter, issues instruction-memory reads and
// buffers fetched words in a 2-entry queue toward decode. Optional trap: PCFS_ALIGN_TRAP_EN.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_out,
  output logic [31:0] pc_in,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        fetch_fault
);

  // state | meaning
  // IDLE  | no request; wait until the queue has room
  // FETCH | request at pc_out outstanding; ack pushes into the queue
  // DROP  | squashed request still outstanding; its data is thrown away
  // FAULT | misaligned redirect seen (trap build only); parked until reset
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DROP  = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [1:0]  count_q, count_d;
  logic        valid_q, valid_d;
  logic [31:0] e0_inst_q, e0_inst_d;
  logic [31:0] e0_pc_q, e0_pc_d;
  logic [31:0] e1_inst_q, e1_inst_d;
  logic [31:0] e1_pc_q, e1_pc_d;
  logic [31:0] addr_q, addr_d;
  logic        fault_q, fault_d;

  logic        redir_ok;
  logic        trap;
  logic        redir;
  logic        flush;
  logic [31:0] redir_target;
  logic        pop;
  logic        push;
  logic [1:0]  count_pop;

  always_comb begin
    redir_ok = redirect_valid && !fault_q && (state_q != FAULT);
`ifdef PCFS_ALIGN_TRAP_EN
    trap         = redir_ok && (redirect_pc[1:0] != 2'b00);
    redir_target = redirect_pc;
`else
    trap         = 1'b0;
    redir_target = redirect_pc & 32'hFFFF_FFFC;
`endif
    redir = redir_ok && !trap;
    flush = redir_ok;
  end

  // A pop in a flush cycle is dropped: the flush empties the queue regardless.
  assign pop       = valid_q && inst_ready && !flush;
  assign count_pop = count_q - {1'b0, pop};

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    fault_d   = fault_q;
    imem_req  = 1'b0;
    imem_addr = pc_out;
    pc_in     = pc_out;
    push      = 1'b0;

    case (state_q)
      IDLE: begin
        if (redir) begin
          state_d = FETCH;
        end else if (trap) begin
          state_d = FAULT;
        end else if (count_pop < 2'd2) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        imem_req = 1'b1;
        addr_d   = pc_out;
        if (flush) begin
          if (imem_ack) begin
            state_d = trap ? FAULT : FETCH;
          end else begin
            state_d = DROP;
          end
        end else if (imem_ack) begin
          push    = 1'b1;
          pc_in   = pc_out + PC_STEP;
          state_d = (count_pop == 2'd0) ? FETCH : IDLE;
        end
      end
      DROP: begin
        imem_req  = 1'b1;
        imem_addr = addr_q;
        if (imem_ack) begin
          state_d = (fault_q || trap) ? FAULT : FETCH;
        end
      end
      default: begin
        state_d = FAULT;
      end
    endcase

    if (redir) begin
      pc_in = redir_target;
    end
    if (trap) begin
      fault_d = 1'b1;
    end
    if (!reset) begin
      pc_in = RESET_PC;
    end
  end

  always_comb begin
    count_d   = count_q;
    e0_inst_d = e0_inst_q;
    e0_pc_d   = e0_pc_q;
    e1_inst_d = e1_inst_q;
    e1_pc_d   = e1_pc_q;

    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            e0_inst_d = imem_rdata;
            e0_pc_d   = pc_out;
          end else begin
            e1_inst_d = imem_rdata;
            e1_pc_d   = pc_out;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          e0_inst_d = e1_inst_q;
          e0_pc_d   = e1_pc_q;
          count_d   = count_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop: occupancy unchanged, head advances.
          if (count_q == 2'd1) begin
            e0_inst_d = imem_rdata;
            e0_pc_d   = pc_out;
          end else begin
            e0_inst_d = e1_inst_q;
            e0_pc_d   = e1_pc_q;
            e1_inst_d = imem_rdata;
            e1_pc_d   = pc_out;
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
    valid_d = (count_d != 2'd0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= 2'd0;
      valid_q   <= 1'b0;
      e0_inst_q <= 32'h0;
      e0_pc_q   <= 32'h0;
      e1_inst_q <= 32'h0;
      e1_pc_q   <= 32'h0;
      addr_q    <= 32'h0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      e0_inst_q <= e0_inst_d;
      e0_pc_q   <= e0_pc_d;
      e1_inst_q <= e1_inst_d;
      e1_pc_q   <= e1_pc_d;
      addr_q    <= addr_d;
      fault_q   <= fault_d;
    end
  end

  assign inst_valid  = valid_q;
  assign inst        = e0_inst_q;
  assign inst_pc     = e0_pc_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: the bench plays program_counter and a
// random-latency instruction memory; expected fetches go into a queue popped by a monitor.
module tb_pc_fetch_sequencer;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc_out;
  logic [31:0] pc_in;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        fetch_fault;

  pc_fetch_sequencer #(.RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
    .clock(clock), .reset(reset), .pc_out(pc_out), .pc_in(pc_in),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst(inst),
    .inst_pc(inst_pc), .inst_ready(inst_ready), .fetch_fault(fetch_fault)
  );

  always #5 clock = ~clock;

  // program_counter: loads pc_in on every edge
  always @(posedge clock) pc_out <= pc_in;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } item_t;

  item_t       exp_q[$];
  item_t       d_item;
  bit          d_push, d_flush;
  int          n_assert = 0;
  int          n_fail = 0;
  bit          run = 0;

  int          ready_pct, redir_pct, lat_max, force_lat;
  bit          force_redir;
  logic [31:0] force_rpc;

  bit          busy, squash, faulted;
  int          lat;
  logic [31:0] req_addr, exp_pc;
  logic [31:0] stream_words [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2008_0005;
      32'h0000_0004: return 32'h2009_0003;
      32'h0000_0008: return 32'h0109_5020;
      default:       return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
    endcase
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2);
    else t = $urandom_range(0, 255) << 2;
`ifndef PCFS_ALIGN_TRAP_EN
    t[1:0] = 2'($urandom_range(0, 3));
`endif
    return t;
  endfunction

  // Stimulus + memory: each cycle picks ready/redirect, answers requests, and
  // records what decode should eventually see.
  initial begin : driver
    bit          rv, eff, trap_c, accepted;
    logic [31:0] rpc, exp_pcin;
    forever begin
      @(posedge clock);
      if (run) begin
        if (d_flush) exp_q.delete();
        if (d_push) exp_q.push_back(d_item);
        d_flush = 0;
        d_push  = 0;
        #1;
        inst_ready = ($urandom_range(0, 99) < ready_pct);
        rv  = force_redir || ($urandom_range(0, 99) < redir_pct);
        rpc = force_redir ? force_rpc : rand_target();
        force_redir = 0;
`ifdef PCFS_ALIGN_TRAP_EN
        eff    = rv && !faulted;
        trap_c = eff && (rpc[1:0] != 2'b00);
`else
        eff    = rv;
        trap_c = 0;
`endif
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_ack = 0;
        accepted = 0;
        if (imem_req) begin
          if (!busy) begin
            busy = 1;
            squash = 0;
            req_addr = imem_addr;
            lat = (force_lat >= 0) ? force_lat : $urandom_range(0, lat_max);
            chk("req_addr", imem_addr, exp_pc);
          end else begin
            chk("addr_hold", imem_addr, req_addr);
          end
          if (eff) squash = 1;
          if (lat == 0) begin
            imem_ack   = 1;
            imem_rdata = mem_word(req_addr);
            busy = 0;
            if (!squash) begin
              accepted = 1;
              d_push = 1;
              d_item = '{pc: req_addr, word: mem_word(req_addr)};
              exp_pc = req_addr + 32'd4;
            end
          end else begin
            lat--;
          end
        end
        if (eff) begin
          d_flush = 1;
          if (trap_c) faulted = 1;
          else exp_pc = rpc & 32'hFFFF_FFFC;
        end
        exp_pcin = (eff && !trap_c) ? (rpc & 32'hFFFF_FFFC) :
                   accepted ? pc_out + 32'd4 : pc_out;
        #1;
        chk("pc_in", pc_in, exp_pcin);
      end
    end
  end

  // Monitor: compares the queue head whenever decode takes an instruction.
  always @(negedge clock) begin
    if (run) begin
      item_t it;
      chk("inst_valid", inst_valid, exp_q.size() != 0);
      if (inst_valid && inst_ready && !redirect_valid && exp_q.size() != 0) begin
        it = exp_q.pop_front();
        chk("inst", inst, it.word);
        chk("inst_pc", inst_pc, it.pc);
      end
    end
  end

  task automatic do_reset();
    run = 0;
    reset = 0;
    redirect_valid = 0;
    redirect_pc = 0;
    imem_ack = 0;
    imem_rdata = 0;
    inst_ready = 0;
    busy = 0;
    squash = 0;
    lat = 0;
    faulted = 0;
    exp_pc = RESET_PC;
    d_flush = 0;
    d_push = 0;
    force_redir = 0;
    exp_q.delete();
    repeat (2) @(posedge clock);
    #2;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_pc_in", pc_in, RESET_PC);
    chk("rst_fault", fetch_fault, 0);
    @(negedge clock);
    reset = 1;
    run = 1;
  endtask

  initial begin
    stream_words[0] = 32'h2008_0005;
    stream_words[1] = 32'h2009_0003;
    stream_words[2] = 32'h0109_5020;
    force_rpc = 0;

    // zero-wait streaming
    ready_pct = 100; redir_pct = 0; lat_max = 0; force_lat = 0;
    do_reset();
    @(posedge clock); #3;
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #3;
      chk("stream_valid", inst_valid, 1);
      chk("stream_pc", inst_pc, 32'(i * 4));
      chk("stream_inst", inst, stream_words[i]);
      chk("stream_pcin", pc_in, pc_out + 32'd4);
    end

    // backpressure
    ready_pct = 0;
    do_reset();
    repeat (3) @(posedge clock);
    #3;
    chk("bp_req", imem_req, 0);
    chk("bp_pcin", pc_in, pc_out);
    chk("bp_inst", inst, 32'h2008_0005);
    ready_pct = 100;
    @(posedge clock); #3;
    ready_pct = 0;
    chk("bp_pop_req", imem_req, 0);
    @(posedge clock); #3;
    chk("bp_next_req", imem_req, 1);
    chk("bp_next_addr", imem_addr, 32'h8);
    chk("bp_head", inst, 32'h2009_0003);

    // 3-cycle latency with redirect one cycle after req
    ready_pct = 100; force_lat = 3;
    do_reset();
    @(posedge clock); #3;
    force_redir = 1; force_rpc = 32'h0040_0000;
    @(posedge clock); #3;
    chk("drop_req", imem_req, 1);
    @(posedge clock); #3;
    chk("drop_addr", imem_addr, 32'h0);
    @(posedge clock); #3;
    chk("drop_addr_ack", imem_addr, 32'h0);
    chk("drop_pcin", pc_in, 32'h0040_0000);
    @(posedge clock); #3;
    chk("redir_addr", imem_addr, 32'h0040_0000);
    chk("redir_valid", inst_valid, 0);
    repeat (6) @(posedge clock);

    // wrap at the top of the address space
    force_lat = 0;
    do_reset();
    force_redir = 1; force_rpc = 32'hFFFF_FFFC;
    @(posedge clock); #3;
    @(posedge clock); #3;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_pcin", pc_in, 32'h0);
    @(posedge clock); #3;
    chk("wrap_valid", inst_valid, 1);
    chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    chk("wrap_next", imem_addr, 32'h0);

    // randomized traffic
    force_lat = -1; lat_max = 3; ready_pct = 60; redir_pct = 6;
    do_reset();
    repeat (3000) @(posedge clock);

    // misaligned redirect
    redir_pct = 0; ready_pct = 100; force_lat = 0;
    do_reset();
    repeat (2) @(posedge clock);
    #3;
    force_redir = 1; force_rpc = 32'h0040_0002;
    @(posedge clock); #3;
    @(posedge clock); #3;
`ifdef PCFS_ALIGN_TRAP_EN
    chk("trap_fault", fetch_fault, 1);
    chk("trap_req", imem_req, 0);
    force_redir = 1; force_rpc = 32'h0000_0100;
    repeat (4) begin
      @(posedge clock); #3;
      chk("trap_hold_req", imem_req, 0);
      chk("trap_hold_fault", fetch_fault, 1);
    end
`else
    chk("mis_addr", imem_addr, 32'h0040_0000);
    chk("mis_req", imem_req, 1);
    chk("mis_fault", fetch_fault, 0);
`endif
    repeat (4) @(posedge clock);
    run = 0;
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
